// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester: single-beat local command to APB transfer with PREADY watchdog
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PSELx,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // A zero limit turns the watchdog off; otherwise abort once the counter
    // has seen TIMEOUT_CYCLES-1 low-PREADY edges plus the current one.
    localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [31:0] paddr_d;
    logic        pwrite_d;
    logic [31:0] pwdata_d;
    logic        psel_d;
    logic        penable_d;
    logic        ready_d;
    logic        rsp_valid_d;
    logic [31:0] rdata_d;
    logic        err_d;
    logic        to_d;

    // State, watchdog counter and every output are registered here
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'd0;
            PADDR         <= 32'd0;
            PWRITE        <= 1'b0;
            PWDATA        <= 32'd0;
            PSELx         <= 1'b0;
            PENABLE       <= 1'b0;
            o_cmd_ready   <= 1'b1;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= 32'd0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            PADDR         <= paddr_d;
            PWRITE        <= pwrite_d;
            PWDATA        <= pwdata_d;
            PSELx         <= psel_d;
            PENABLE       <= penable_d;
            o_cmd_ready   <= ready_d;
            o_rsp_valid   <= rsp_valid_d;
            o_rsp_rdata   <= rdata_d;
            o_rsp_err     <= err_d;
            o_rsp_timeout <= to_d;
        end
    end

    // Next state and next output values; outputs reflect the state being entered
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = PADDR;
        pwrite_d    = PWRITE;
        pwdata_d    = PWDATA;
        psel_d      = PSELx;
        penable_d   = PENABLE;
        ready_d     = o_cmd_ready;
        rsp_valid_d = 1'b0;
        rdata_d     = o_rsp_rdata;
        err_d       = o_rsp_err;
        to_d        = o_rsp_timeout;
        case (state_q)
            ST_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                ready_d   = 1'b1;
                if (i_cmd_valid && o_cmd_ready) begin
                    state_d  = ST_SETUP;
                    paddr_d  = i_cmd_addr;
                    pwrite_d = i_cmd_write;
                    pwdata_d = i_cmd_write ? i_cmd_wdata : 32'd0;
                    psel_d   = 1'b1;
                    ready_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                cnt_d     = 16'd0;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                ready_d   = 1'b0;
            end
            ST_ACCESS: begin
                // PREADY is checked first so a completion on the limit edge is not lost
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rdata_d     = PWRITE ? 32'd0 : PRDATA;
                    err_d       = PSLVERR;
                    to_d        = 1'b0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d     = ST_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rdata_d     = 32'd0;
                    err_d       = 1'b1;
                    to_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                ready_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
module tb_apb_master;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_write = 1'b0;
    logic [31:0] i_cmd_addr = 32'd0;
    logic [31:0] i_cmd_wdata = 32'd0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_rsp_timeout;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PSELx;
    logic        PENABLE;
    logic [31:0] PRDATA = 32'd0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    apb_master #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_write  (i_cmd_write),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_wdata  (i_cmd_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_timeout(o_rsp_timeout),
        .PADDR        (PADDR),
        .PWRITE       (PWRITE),
        .PWDATA       (PWDATA),
        .PSELx        (PSELx),
        .PENABLE      (PENABLE),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_xfer(input string nm, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits, input logic [31:0] prdata,
                            input logic slverr, input int exp_acc, input logic [31:0] exp_rdata,
                            input logic exp_err, input logic exp_to);
        int          acc;
        logic [31:0] exp_pwdata;
        exp_pwdata  = wr ? wdata : 32'd0;
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        PRDATA      = prdata;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        chk({nm, "_ready"}, 32'(o_cmd_ready), 32'd1);
        tick();
        i_cmd_valid = 1'b0;
        i_cmd_write = ~wr;
        i_cmd_addr  = 32'hFFFF_FFFF;
        i_cmd_wdata = 32'h5555_5555;
        chk({nm, "_setup_psel"}, 32'(PSELx), 32'd1);
        chk({nm, "_setup_pen"}, 32'(PENABLE), 32'd0);
        chk({nm, "_setup_ready"}, 32'(o_cmd_ready), 32'd0);
        chk({nm, "_paddr"}, PADDR, addr);
        chk({nm, "_pwrite"}, 32'(PWRITE), 32'(wr));
        chk({nm, "_pwdata"}, PWDATA, exp_pwdata);
        acc = 0;
        tick();
        while (PSELx === 1'b1 && acc < 40) begin
            acc++;
            chk({nm, "_acc_pen"}, 32'(PENABLE), 32'd1);
            chk({nm, "_acc_paddr"}, PADDR, addr);
            chk({nm, "_acc_rsp"}, 32'(o_rsp_valid), 32'd0);
            PREADY  = (acc > waits);
            PSLVERR = (acc > waits) ? slverr : 1'b0;
            tick();
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        chk({nm, "_acc_len"}, 32'(acc), 32'(exp_acc));
        chk({nm, "_rsp_valid"}, 32'(o_rsp_valid), 32'd1);
        chk({nm, "_rdata"}, o_rsp_rdata, exp_rdata);
        chk({nm, "_err"}, 32'(o_rsp_err), 32'(exp_err));
        chk({nm, "_timeout"}, 32'(o_rsp_timeout), 32'(exp_to));
        chk({nm, "_rsp_pen"}, 32'(PENABLE), 32'd0);
        chk({nm, "_rsp_ready"}, 32'(o_cmd_ready), 32'd1);
        tick();
        chk({nm, "_pulse_end"}, 32'(o_rsp_valid), 32'd0);
        chk({nm, "_rdata_hold"}, o_rsp_rdata, exp_rdata);
        chk({nm, "_paddr_hold"}, PADDR, addr);
    endtask

    initial begin
        logic [11:0] psel_tr;
        logic [11:0] rsp_tr;
        int          n_acc;
        int          rsp_seen;
        logic        rdy_b;
        logic        psel_b;

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_psel", 32'(PSELx), 32'd0);
        chk("rst_pen", 32'(PENABLE), 32'd0);
        chk("rst_ready", 32'(o_cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_rdata", o_rsp_rdata, 32'd0);
        chk("rst_err", 32'(o_rsp_err), 32'd0);
        chk("rst_to", 32'(o_rsp_timeout), 32'd0);
        i_reset = 1'b0;
        tick();

        run_xfer("wr0", 1'b1, 32'h4, 32'hDEAD_BEEF, 0, 32'hA5A5_A5A5, 1'b0, 1, 32'd0, 1'b0, 1'b0);
        run_xfer("rd_wait", 1'b0, 32'h2, 32'hFFFF_0000, 2, 32'h1234_5678, 1'b0, 3, 32'h1234_5678, 1'b0, 1'b0);
        run_xfer("wr_err", 1'b1, 32'h20, 32'h0000_CAFE, 0, 32'h0, 1'b1, 1, 32'd0, 1'b1, 1'b0);
        run_xfer("rd_to", 0, 32'h30, 32'h0, 1000, 32'h1111_2222, 1'b0, 4, 32'd0, 1'b1, 1'b1);
        run_xfer("rd_late", 0, 32'h34, 32'h0, 3, 32'h0BAD_F00D, 1'b0, 4, 32'h0BAD_F00D, 1'b0, 1'b0);

        PREADY      = 1'b1;
        PSLVERR     = 1'b0;
        PRDATA      = 32'd0;
        n_acc       = 0;
        psel_tr     = '0;
        rsp_tr      = '0;
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b1;
        i_cmd_addr  = 32'h100;
        i_cmd_wdata = 32'h1;
        for (int i = 0; i < 12; i++) begin
            rdy_b  = o_cmd_ready;
            psel_b = PSELx;
            tick();
            psel_tr[11-i] = PSELx;
            rsp_tr[11-i]  = o_rsp_valid;
            if (rdy_b && i_cmd_valid) begin
                chk("b2b_accept_idle", 32'(psel_b), 32'd0);
                chk("b2b_paddr", PADDR, i_cmd_addr);
                chk("b2b_pwdata", PWDATA, i_cmd_wdata);
                n_acc++;
                if (n_acc == 3) begin
                    i_cmd_valid = 1'b0;
                end else begin
                    i_cmd_addr  = i_cmd_addr + 32'd4;
                    i_cmd_wdata = i_cmd_wdata + 32'd1;
                end
            end
        end
        chk("b2b_accepts", 32'(n_acc), 32'd3);
        chk("b2b_psel_trace", 32'(psel_tr), 32'(12'b1101_1011_0000));
        chk("b2b_rsp_trace", 32'(rsp_tr), 32'(12'b0010_0100_1000));
        PREADY = 1'b0;

        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b0;
        i_cmd_addr  = 32'h40;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        chk("rst_mid_psel_pre", 32'(PSELx), 32'd1);
        chk("rst_mid_pen_pre", 32'(PENABLE), 32'd1);
        #3;
        i_reset = 1'b1;
        #1;
        chk("rst_mid_psel", 32'(PSELx), 32'd0);
        chk("rst_mid_pen", 32'(PENABLE), 32'd0);
        rsp_seen = 0;
        repeat (3) begin
            tick();
            if (o_rsp_valid) rsp_seen++;
        end
        i_reset = 1'b0;
        repeat (2) begin
            tick();
            if (o_rsp_valid) rsp_seen++;
        end
        chk("rst_mid_no_rsp", 32'(rsp_seen), 32'd0);
        chk("rst_mid_idle_psel", 32'(PSELx), 32'd0);
        run_xfer("post_rst", 1'b0, 32'h44, 32'h0, 0, 32'hCAFE_0001, 1'b0, 1, 32'hCAFE_0001, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
